// File: rtl/mem_load_unit_pkg.sv
// Shared load/store width codes, load FSM states and error causes.
// Also imported by the store mask generator.
package mem_load_unit_pkg;

  localparam logic [2:0] WIDTH_NONE = 3'b000;
  localparam logic [2:0] WIDTH_D    = 3'b001;
  localparam logic [2:0] WIDTH_W    = 3'b010;
  localparam logic [2:0] WIDTH_H    = 3'b011;
  localparam logic [2:0] WIDTH_B    = 3'b100;
  localparam logic [2:0] WIDTH_WU   = 3'b101;
  localparam logic [2:0] WIDTH_HU   = 3'b110;
  localparam logic [2:0] WIDTH_BU   = 3'b111;

  localparam logic ERR_MISALIGN = 1'b0;
  localparam logic ERR_TIMEOUT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } ld_state_e;

  function automatic logic misaligned(
    input logic [2:0] w,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (w)
      WIDTH_D:           m = off != 3'b000;
      WIDTH_W, WIDTH_WU: m = off[1:0] != 2'b00;
      WIDTH_H, WIDTH_HU: m = off[0];
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Pipeline request/result and data-memory read port of the load unit.
// slave = load unit side, master = pipeline + memory side.
interface mem_load_unit_if;

  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [2:0]  memdata_width;
  logic        busy;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ld_done;
  logic [63:0] ld_data;
  logic        ld_err;
  logic        ld_err_cause;

  modport slave (
    input  ld_valid, ld_addr, memdata_width,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy, mem_req, mem_addr,
    output ld_done, ld_data, ld_err, ld_err_cause
  );

  modport master (
    output ld_valid, ld_addr, memdata_width,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy, mem_req, mem_addr,
    input  ld_done, ld_data, ld_err, ld_err_cause
  );

endinterface

// File: rtl/mem_load_unit_load_extract.sv
// Selects the addressed field of an aligned doubleword and
// sign- or zero-extends it to 64 bits.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  width,
  output logic [63:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  assign b = 8'(rdata >> {offset, 3'b000});
  assign h = 16'(rdata >> {offset[2:1], 4'b0000});
  assign w = 32'(rdata >> {offset[2], 5'b00000});

  always_comb begin
    data = '0;
    unique case (width)
      WIDTH_D:  data = rdata;
      WIDTH_W:  data = {{32{w[31]}}, w};
      WIDTH_WU: data = {32'b0, w};
      WIDTH_H:  data = {{48{h[15]}}, h};
      WIDTH_HU: data = {48'b0, h};
      WIDTH_B:  data = {{56{b[7]}}, b};
      WIDTH_BU: data = {56'b0, b};
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Memory-stage load unit: one aligned 8-byte read per load,
// field extraction, misalign and timeout reporting.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  mem_load_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  ld_state_e        state_q;
  logic [2:0]       off_q;
  logic [2:0]       wid_q;
  logic [60:0]      base_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             req_q;
  logic             done_q;
  logic             err_q;
  logic             cause_q;
  logic [63:0]      data_q;
  logic [63:0]      data_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  load_extract u_extract (
    .rdata  (bus.mem_rdata),
    .offset (off_q),
    .width  (wid_q),
    .data   (data_d)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      wid_q   <= WIDTH_NONE;
      base_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.ld_valid &&
              bus.memdata_width != WIDTH_NONE) begin
            off_q  <= bus.ld_addr[2:0];
            wid_q  <= bus.memdata_width;
            base_q <= bus.ld_addr[63:3];
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (misaligned(bus.memdata_width,
                           bus.ld_addr[2:0])) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              cause_q <= ERR_MISALIGN;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // data arriving on the expiry cycle still completes
          if (bus.mem_rvalid) begin
            state_q <= S_DONE;
            data_q  <= data_d;
            done_q  <= 1'b1;
          end else if (cnt_d == TMO) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            cause_q <= ERR_TIMEOUT;
          end
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.mem_req      = req_q;
  assign bus.mem_addr     = {base_q, 3'b000};
  assign bus.ld_done      = done_q;
  assign bus.ld_data      = data_q;
  assign bus.ld_err       = err_q;
  assign bus.ld_err_cause = cause_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: directed loads push expected
// completions; a negedge monitor pops and compares them.
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  localparam int TMO = 16;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    string       name;
    bit          err;
    logic        cause;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] last_data;

  mem_load_unit_if bus();

  mem_load_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ld_done || bus.ld_err) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b, none expected",
                 bus.ld_done, bus.ld_err);
      end else begin
        e = sbq.pop_front();
        chk({e.name, ".kind"}, {62'b0, bus.ld_done, bus.ld_err},
            {62'b0, !e.err, e.err});
        chk({e.name, ".cycle"}, 64'(cyc), 64'(e.cyc));
        chk({e.name, ".data"}, bus.ld_data, e.data);
        if (e.err)
          chk({e.name, ".cause"}, {63'b0, bus.ld_err_cause},
              {63'b0, e.cause});
      end
    end
  end

  task automatic do_load(input string nm, input logic [63:0] a,
                         input logic [2:0] w, input logic [63:0] rd,
                         input int g, input int r, input bit mis,
                         input logic [63:0] exp);
    exp_t e;
    int   c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    e.name = nm;
    if (mis) begin
      e.err = 1; e.cause = ERR_MISALIGN;
      e.data = last_data; e.cyc = c0 + 1;
    end else if (r < 0) begin
      e.err = 1; e.cause = ERR_TIMEOUT;
      e.data = last_data; e.cyc = c0 + 2 + g + TMO;
    end else begin
      e.err = 0; e.cause = 1'b0;
      e.data = exp; e.cyc = c0 + 3 + g + r;
      last_data = exp;
    end
    sbq.push_back(e);
    bus.ld_valid = 1'b1;
    bus.ld_addr = a;
    bus.memdata_width = w;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    if (mis) begin
      repeat (3) begin
        chk({nm, ".no_req"}, {63'b0, bus.mem_req}, 64'd0);
        @(posedge clk);
        #1;
      end
      return;
    end
    for (int i = 0; i < g; i++) begin
      chk({nm, ".req"}, {63'b0, bus.mem_req}, 64'd1);
      chk({nm, ".addr"}, bus.mem_addr, {a[63:3], 3'b000});
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk);
      #1;
    end
    bus.mem_rvalid = 1'b0;
    chk({nm, ".req"}, {63'b0, bus.mem_req}, 64'd1);
    chk({nm, ".addr"}, bus.mem_addr, {a[63:3], 3'b000});
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_gnt = 1'b0;
    chk({nm, ".req_drop"}, {63'b0, bus.mem_req}, 64'd0);
    if (r < 0) begin
      repeat (TMO + 2) @(posedge clk);
      #1;
      return;
    end
    repeat (r) @(posedge clk);
    #1;
    bus.mem_rdata = rd;
    bus.mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, ".busy"}, {63'b0, bus.busy}, 64'd0);
    chk({nm, ".mem_req"}, {63'b0, bus.mem_req}, 64'd0);
    chk({nm, ".mem_addr"}, bus.mem_addr, 64'd0);
    chk({nm, ".ld_done"}, {63'b0, bus.ld_done}, 64'd0);
    chk({nm, ".ld_data"}, bus.ld_data, 64'd0);
    chk({nm, ".ld_err"}, {63'b0, bus.ld_err}, 64'd0);
    chk({nm, ".cause"}, {63'b0, bus.ld_err_cause}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_data = '0;
    rstn = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr = '0;
    bus.memdata_width = WIDTH_NONE;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rstn = 1'b1;

    // width 000 is not a load
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b1;
    bus.ld_addr = 64'h1000;
    bus.memdata_width = WIDTH_NONE;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    chk("none.busy", {63'b0, bus.busy}, 64'd0);
    chk("none.req", {63'b0, bus.mem_req}, 64'd0);

    do_load("lb_1003", 64'h1003, WIDTH_B, 64'h0000_0000_80FF_0000,
            0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lb_1002", 64'h1002, WIDTH_B, 64'h0000_0000_80FF_0000,
            0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_load("lbu_1001", 64'h1001, WIDTH_BU, 64'h0000_0000_80FF_0000,
            0, 0, 0, 64'h0);
    do_load("lhu_2006", 64'h2006, WIDTH_HU, 64'h8001_0000_0000_0000,
            0, 0, 0, 64'h0000_0000_0000_8001);
    do_load("lh_2006", 64'h2006, WIDTH_H, 64'h8001_0000_0000_0000,
            0, 0, 0, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lw_3002_mis", 64'h3002, WIDTH_W, '0, 0, 0, 1, '0);
    do_load("ld_4004_mis", 64'h4004, WIDTH_D, '0, 0, 0, 1, '0);
    do_load("lhu_4001_mis", 64'h4001, WIDTH_HU, '0, 0, 0, 1, '0);
    do_load("lb_4007", 64'h4007, WIDTH_B, 64'h7F00_0000_0000_0000,
            1, 2, 0, 64'h0000_0000_0000_007F);
    do_load("ld_4000_tmo", 64'h4000, WIDTH_D, '0, 3, -1, 0, '0);
    do_load("lw_5004_edge", 64'h5004, WIDTH_W, 64'hDEAD_BEEF_1234_5678,
            0, TMO - 1, 0, 64'hFFFF_FFFF_DEAD_BEEF);

    fork
      do_load("lwu_5004", 64'h5004, WIDTH_WU, 64'hDEAD_BEEF_1234_5678,
              0, 3, 0, 64'h0000_0000_DEAD_BEEF);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.ld_valid = 1'b1;
        bus.ld_addr = 64'h6000;
        bus.memdata_width = WIDTH_B;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("busy_ignore.busy", {63'b0, bus.busy}, 64'd0);
    chk("busy_ignore.req", {63'b0, bus.mem_req}, 64'd0);

    do_load("ld_5000", 64'h5000, WIDTH_D, 64'hDEAD_BEEF_1234_5678,
            2, 1, 0, 64'hDEAD_BEEF_1234_5678);

    // reset while waiting for read data, then a stale response
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b1;
    bus.ld_addr = 64'h7008;
    bus.memdata_width = WIDTH_D;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_gnt = 1'b0;
    chk("rst_wait.busy", {63'b0, bus.busy}, 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_data = '0;
    chk_idle_zero("rst_wait");
    bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    bus.mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    repeat (TMO + 3) @(posedge clk);
    #1;
    chk("rst_late.busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_late.data", bus.ld_data, 64'd0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
